// File: rtl/ep_adder_arbiter_pkg.sv
// Shared arbiter constants and round-robin pick helper.
// Used by the endpoint adder arbiter and its picker.
package ep_arb_pkg;

  localparam int MAX_N = 8;
  localparam int W_DEF = 32;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // first valid slot at or after ptr, wrapping at n
  function automatic rr_pick_t rr_pick(
    input logic [MAX_N-1:0] valid,
    input int               n,
    input int               ptr
  );
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_N; k++) begin
      j = (ptr + k) % n;
      if (k < n && !r.found && valid[j[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ep_adder_arbiter_if.sv
// Requester/result bundle between endpoint fabric
// and the shared adder arbiter.
interface ep_adder_arbiter_if
  import ep_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = W_DEF
);

  logic           hold;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N*W-1:0] rsp_data;
  logic [N-1:0]   rsp_carry;
  logic           busy;

  modport master (
    output hold, req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_carry, busy
  );

  modport slave (
    input  hold, req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data,
    output rsp_carry, busy
  );

endinterface

// File: rtl/ep_adder_arbiter_rr_picker.sv
// Combinational round-robin selector, reusable
// by any endpoint arbiter with up to MAX_N slots.
module rr_picker
  import ep_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  rr_pick_t pick;

  // search from ptr upward with wrap
  always_comb begin
    pick = rr_pick(MAX_N'(valid), N, int'(ptr));
  end

  assign found = pick.found;
  assign idx   = PW'(pick.idx);

endmodule

// File: rtl/ep_adder_arbiter.sv
// Round-robin shared registered adder for N host
// requesters with per-requester held results.
module ep_adder_arbiter
  import ep_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = W_DEF
) (
  input logic ti_clk,
  input logic rst_n,
  ep_adder_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win;
  logic           found;
  logic           hs;

  logic           s1_valid;
  logic [PW-1:0]  s1_id;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;

  logic           s2_valid;
  logic [PW-1:0]  s2_id;
  logic [W-1:0]   s2_sum;
  logic           s2_carry;

  logic [N-1:0]   rv_q;
  logic [N-1:0]   rc_q;
  logic [N*W-1:0] rd_q;

  rr_picker #(.N(N)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .found (found),
    .idx   (win)
  );

  assign hs            = found & ~bus.hold;
  assign bus.req_ready = hs ? (N'(1) << win) : '0;

  // advance pointer past the winner on handshake
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  // stage 1: capture the granted operand pair
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= hs;
      if (hs) begin
        s1_id <= win;
        s1_a  <= bus.req_a[int'(win) * W +: W];
        s1_b  <= bus.req_b[int'(win) * W +: W];
      end
    end
  end

  // stage 2: the shared W+1 bit adder
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_sum   <= '0;
      s2_carry <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      {s2_carry, s2_sum} <= {1'b0, s1_a} + {1'b0, s1_b};
    end
  end

  // writeback into the owner's held result slot
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= '0;
      rc_q <= '0;
      rd_q <= '0;
    end else begin
      rv_q <= '0;
      if (s2_valid) begin
        rv_q[s2_id] <= 1'b1;
        rc_q[s2_id] <= s2_carry;
        rd_q[int'(s2_id) * W +: W] <= s2_sum;
      end
    end
  end

  assign bus.rsp_valid = rv_q;
  assign bus.rsp_carry = rc_q;
  assign bus.rsp_data  = rd_q;
  assign bus.busy      = s1_valid | s2_valid | (|rv_q);

endmodule

// File: tb/tb_ep_adder_arbiter.sv
// Directed + random bench for ep_adder_arbiter
// against a queue-based latency model.
module tb_ep_adder_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ep_adder_arbiter_if #(.N(N), .W(W)) bus ();

  ep_adder_arbiter #(.N(N), .W(W)) dut (
    .ti_clk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int         id;
    logic [W:0] sum;
    int         age;
  } op_t;

  op_t        pend[$];
  int         m_ptr;
  logic [W-1:0] e_data  [N];
  logic         e_carry [N];
  logic         e_valid [N];
  int           pulses  [N];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner(logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_clear();
    pend.delete();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      e_data[i]  = '0;
      e_carry[i] = 1'b0;
      e_valid[i] = 1'b0;
    end
  endtask

  task automatic check_outputs(string tag);
    int   w;
    logic any_v;
    logic [N-1:0] er;
    w  = m_winner(bus.req_valid);
    er = (w >= 0 && !bus.hold) ? N'(1) << w : '0;
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'(er));
    any_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      any_v |= e_valid[i];
      chk($sformatf("%s.valid%0d", tag, i),
          64'(bus.rsp_valid[i]), 64'(e_valid[i]));
      chk($sformatf("%s.data%0d", tag, i),
          64'(bus.rsp_data[i*W +: W]), 64'(e_data[i]));
      chk($sformatf("%s.carry%0d", tag, i),
          64'(bus.rsp_carry[i]), 64'(e_carry[i]));
    end
    chk({tag, ".busy"}, 64'(bus.busy),
        64'(pend.size() > 0 || any_v));
  endtask

  // one clock: check before the edge, advance model at the edge
  task automatic step(string tag, output int gw);
    op_t  op;
    logic [W-1:0] a, b;
    #1;
    check_outputs(tag);
    gw = bus.hold ? -1 : m_winner(bus.req_valid);
    a  = (gw >= 0) ? bus.req_a[gw*W +: W] : '0;
    b  = (gw >= 0) ? bus.req_b[gw*W +: W] : '0;
    @(posedge clk);
    for (int i = 0; i < N; i++) e_valid[i] = 1'b0;
    foreach (pend[i]) pend[i].age++;
    while (pend.size() > 0 && pend[0].age >= 2) begin
      op = pend.pop_front();
      e_data[op.id]  = op.sum[W-1:0];
      e_carry[op.id] = op.sum[W];
      e_valid[op.id] = 1'b1;
    end
    if (gw >= 0) begin
      op.id  = gw;
      op.sum = {1'b0, a} + {1'b0, b};
      op.age = 0;
      pend.push_back(op);
      m_ptr = (gw + 1) % N;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (bus.rsp_valid[i]) pulses[i]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  initial begin
    int gw;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    model_clear();
    @(negedge clk);
    do_reset();
    step("idle", gw);
    step("idle", gw);
    chk("rst_busy", 64'(bus.busy), 64'd0);

    set_op(0, 32'h3, 32'h4);
    bus.req_valid = 2'b01;
    step("r0", gw);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) step("r0_drain", gw);
    chk("r0_sum", 64'(bus.rsp_data[0 +: W]), 64'h7);
    chk("r1_idle", 64'(bus.rsp_data[W +: W]), 64'h0);
    chk("r0_pulses", 64'(pulses[0]), 64'd1);

    set_op(1, 32'hFFFF_FFFF, 32'h2);
    bus.req_valid = 2'b10;
    step("ovf1", gw);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) step("ovf1_drain", gw);
    chk("ovf1_sum", 64'(bus.rsp_data[W +: W]), 64'h1);
    chk("ovf1_carry", 64'(bus.rsp_carry[1]), 64'h1);

    pulses[0] = 0;
    pulses[1] = 0;
    set_op(0, $urandom, $urandom);
    set_op(1, $urandom, $urandom);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_order", 64'(bus.req_ready),
          (k % 2 == 0) ? 64'h1 : 64'h2);
      step("rr", gw);
      if (gw >= 0) set_op(gw, $urandom, $urandom);
    end
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) step("rr_drain", gw);
    chk("rr_pulses0", 64'(pulses[0]), 64'd3);
    chk("rr_pulses1", 64'(pulses[1]), 64'd3);

    set_op(0, 32'hFFFF_FFFF, 32'h1);
    bus.req_valid = 2'b01;
    step("ovf0", gw);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) step("ovf0_drain", gw);
    chk("ovf0_sum", 64'(bus.rsp_data[0 +: W]), 64'h0);
    chk("ovf0_carry", 64'(bus.rsp_carry[0]), 64'h1);

    bus.req_valid = 2'b11;
    step("hold_pre", gw);
    step("hold_g0", gw);
    bus.hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hold_ready", 64'(bus.req_ready), 64'h0);
      step("hold", gw);
    end
    bus.hold = 1'b0;
    #1;
    chk("hold_resume", 64'(bus.req_ready), 64'h2);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) step("hold_drain", gw);

    pulses[0] = 0;
    set_op(0, 32'h10, 32'h20);
    bus.req_valid = 2'b01;
    step("mid_rst_hs", gw);
    bus.req_valid = 2'b00;
    do_reset();
    for (int k = 0; k < 4; k++) step("post_rst", gw);
    chk("rst_no_pulse", 64'(pulses[0]), 64'd0);
    chk("rst_data0", 64'(bus.rsp_data[0 +: W]), 64'h0);
    bus.req_valid = 2'b11;
    #1;
    chk("rst_ptr0", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 2'b00;
    step("post_rst2", gw);

    for (int k = 0; k < 300; k++) begin
      bus.req_valid = N'($urandom);
      bus.hold      = ($urandom_range(0, 3) == 0);
      step("rand", gw);
      if (gw >= 0) set_op(gw, $urandom, $urandom);
    end
    bus.req_valid = '0;
    bus.hold      = 1'b0;
    for (int k = 0; k < 4; k++) step("rand_drain", gw);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
